// File: rtl/dma_shared_ram_port.sv
// Single-port arbiter for the 8 KB shared work/sprite RAM: CPU has absolute priority,
// the video DMA reader is served from a hold register backed by a 1-entry sequential prefetch.
// Read data returns RD_LAT cycles after issue; dma_wait holds the reader until its byte is held.
module dma_shared_ram_port #(
  parameter int AW     = 13,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  input  logic [AW-1:0] dma_addr,
  input  logic          dma_en,
  output logic          dma_wait,
  output logic [DW-1:0] dma_data,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {SRC_CPU = 2'd0, SRC_DMA = 2'd1, SRC_PF = 2'd2} src_e;

  // read pipe: one entry per cycle of RAM read latency
  logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d, pipe_kill;
  src_e              pipe_src_q  [RD_LAT];
  src_e              pipe_src_d  [RD_LAT];
  logic [AW-1:0]     pipe_addr_q [RD_LAT];
  logic [AW-1:0]     pipe_addr_d [RD_LAT];

  // hold register (byte presented to the reader) and prefetch slot
  logic          hold_vld_q, hold_vld_d;
  logic [AW-1:0] hold_addr_q, hold_addr_d;
  logic [DW-1:0] dma_data_q, dma_data_d;
  logic          pf_vld_q, pf_vld_d;
  logic [AW-1:0] pf_addr_q, pf_addr_d;
  logic [DW-1:0] pf_data_q, pf_data_d;
  logic [DW-1:0] cpu_dout_q;

  logic          cpu_op, cpu_wr_eff;
  logic          hit, pf_match, dma_inflight, pf_inflight;
  logic          dma_issue, pf_issue, promote;
  logic          iss_vld;
  src_e          iss_src;
  logic [AW-1:0] pf_next_addr, ret_addr, ret_next_addr;
  logic          ret_vld, ret_cpu, ret_dp, ret_to_hold, ret_to_pf;
  src_e          ret_src;

  // rd+wr together is a write; nothing reaches the RAM while reset is high
  assign cpu_op     = (cpu_rd | cpu_wr) & ~reset;
  assign cpu_wr_eff = cpu_wr & ~reset;

  assign hit      = hold_vld_q & (hold_addr_q == dma_addr);
  assign dma_wait = reset | (dma_en & ~hit);
  assign pf_match = pf_vld_q & (pf_addr_q == dma_addr);

  assign pf_next_addr = hold_addr_q + 1'b1;

  // scan the pipe for in-flight reader traffic and entries a CPU write or dma_en drop must kill
  always_comb begin
    dma_inflight = 1'b0;
    pf_inflight  = 1'b0;
    pipe_kill    = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      if (pipe_vld_q[i] && pipe_src_q[i] != SRC_CPU) begin
        if (pipe_addr_q[i] == dma_addr) dma_inflight = 1'b1;
        if (!dma_en || (cpu_wr_eff && cpu_addr == pipe_addr_q[i])) pipe_kill[i] = 1'b1;
      end
      if (pipe_vld_q[i] && pipe_src_q[i] == SRC_PF) pf_inflight = 1'b1;
    end
  end

  assign dma_issue = ~reset & dma_en & dma_wait & ~dma_inflight & ~pf_match & ~cpu_op;
  assign pf_issue  = ~reset & hold_vld_q & dma_en & ~pf_vld_q & ~pf_inflight
                   & ~cpu_op & ~dma_issue;
  assign promote   = dma_en & pf_match & ~hit & ~(cpu_wr_eff & (cpu_addr == pf_addr_q));

  // port mux: CPU, then reader miss, then prefetch
  always_comb begin
    ram_addr = cpu_addr;
    iss_vld  = 1'b0;
    iss_src  = SRC_CPU;
    if (cpu_op) begin
      iss_vld = cpu_rd & ~cpu_wr;
    end else if (dma_issue) begin
      ram_addr = dma_addr;
      iss_vld  = 1'b1;
      iss_src  = SRC_DMA;
    end else if (pf_issue) begin
      ram_addr = pf_next_addr;
      iss_vld  = 1'b1;
      iss_src  = SRC_PF;
    end
  end

  assign ram_we  = cpu_wr_eff;
  assign ram_din = cpu_din;

  // return stage: a kill in the return cycle means a same-cycle write wins over the return
  assign ret_vld       = pipe_vld_q[RD_LAT-1];
  assign ret_src       = pipe_src_q[RD_LAT-1];
  assign ret_addr      = pipe_addr_q[RD_LAT-1];
  assign ret_next_addr = ret_addr + 1'b1;
  assign ret_cpu       = ret_vld & (ret_src == SRC_CPU);
  assign ret_dp        = ret_vld & (ret_src != SRC_CPU) & ~pipe_kill[RD_LAT-1];
  assign ret_to_hold   = ret_dp & (ret_addr == dma_addr);
  assign ret_to_pf     = ret_dp & ~ret_to_hold & (ret_src == SRC_PF);

  // shift the read pipe, dropping killed reader entries as they advance
  always_comb begin
    pipe_vld_d[0]  = iss_vld;
    pipe_src_d[0]  = iss_src;
    pipe_addr_d[0] = ram_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1] & ~pipe_kill[i-1];
      pipe_src_d[i]  = pipe_src_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end
  end

  // hold/prefetch next state: invalidations first, then loads
  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_addr_d = hold_addr_q;
    dma_data_d  = dma_data_q;
    pf_vld_d    = pf_vld_q;
    pf_addr_d   = pf_addr_q;
    pf_data_d   = pf_data_q;
    if (!dma_en) begin
      hold_vld_d = 1'b0;
      pf_vld_d   = 1'b0;
    end
    if (cpu_wr_eff && cpu_addr == hold_addr_q) hold_vld_d = 1'b0;
    if (cpu_wr_eff && cpu_addr == pf_addr_q)   pf_vld_d   = 1'b0;
    if (promote) begin
      hold_vld_d  = 1'b1;
      hold_addr_d = pf_addr_q;
      dma_data_d  = pf_data_q;
      pf_vld_d    = 1'b0;
    end
    if (ret_to_hold) begin
      hold_vld_d  = 1'b1;
      hold_addr_d = ret_addr;
      dma_data_d  = ram_dout;
      // reader jumped: a prefetch that no longer follows the hold can never be used
      if (pf_vld_q && pf_addr_q != ret_next_addr) pf_vld_d = 1'b0;
    end
    if (ret_to_pf) begin
      pf_vld_d  = 1'b1;
      pf_addr_d = ret_addr;
      pf_data_d = ram_dout;
    end
  end

  // register pipe, hold, prefetch and CPU read data
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_src_q[i]  <= SRC_CPU;
        pipe_addr_q[i] <= '0;
      end
      hold_vld_q  <= 1'b0;
      hold_addr_q <= '0;
      dma_data_q  <= '0;
      pf_vld_q    <= 1'b0;
      pf_addr_q   <= '0;
      pf_data_q   <= '0;
      cpu_dout_q  <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_src_q[i]  <= pipe_src_d[i];
        pipe_addr_q[i] <= pipe_addr_d[i];
      end
      hold_vld_q  <= hold_vld_d;
      hold_addr_q <= hold_addr_d;
      dma_data_q  <= dma_data_d;
      pf_vld_q    <= pf_vld_d;
      pf_addr_q   <= pf_addr_d;
      pf_data_q   <= pf_data_d;
      if (ret_cpu) cpu_dout_q <= ram_dout;
    end
  end

  assign cpu_dout = cpu_dout_q;
  assign dma_data = dma_data_q;

endmodule

// File: tb/tb_dma_shared_ram_port.sv
// Directed bench for dma_shared_ram_port with a 1-cycle-latency behavioural RAM.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_dma_shared_ram_port;
  localparam int AW     = 13;
  localparam int DW     = 8;
  localparam int RD_LAT = 1;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic [AW-1:0] cpu_addr;
  logic          cpu_rd, cpu_wr;
  logic [DW-1:0] cpu_din, cpu_dout;
  logic [AW-1:0] dma_addr;
  logic          dma_en, dma_wait;
  logic [DW-1:0] dma_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din, ram_dout;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem     [8192];
  logic [7:0] exp_mem [8192];
  logic       tb_preload;

  always #5 clk_sys = ~clk_sys;

  dma_shared_ram_port #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .cpu_addr(cpu_addr),
    .cpu_rd  (cpu_rd),
    .cpu_wr  (cpu_wr),
    .cpu_din (cpu_din),
    .cpu_dout(cpu_dout),
    .dma_addr(dma_addr),
    .dma_en  (dma_en),
    .dma_wait(dma_wait),
    .dma_data(dma_data),
    .ram_addr(ram_addr),
    .ram_we  (ram_we),
    .ram_din (ram_din),
    .ram_dout(ram_dout)
  );

  function automatic logic [7:0] init_byte(input int a);
    logic [12:0] v;
    v = a[12:0];
    return v[7:0] ^ {3'b000, v[12:8]};
  endfunction

  // behavioural RAM: read-before-write, one cycle read latency
  always @(posedge clk_sys) begin
    if (tb_preload) begin
      for (int a = 0; a < 8192; a++) mem[a] <= init_byte(a);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // waits (bounded) for dma_wait low; n = cycles spent with dma_wait high
  task automatic wait_hit(output int n);
    n = 0;
    @(negedge clk_sys);
    while (dma_wait && n < 20) begin
      step();
      n++;
      @(negedge clk_sys);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; dma_en = 1'b1; dma_addr = 13'h0010;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_din = '0;
    tb_preload = 1'b1;
    for (int a = 0; a < 8192; a++) exp_mem[a] = init_byte(a);
    step();
    tb_preload = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      total += 4;
      if (dma_wait !== 1'b1) begin bad++; $display("FAIL reset_wait got=%b exp=1", dma_wait); end
      if (dma_data !== 8'h00) begin bad++; $display("FAIL reset_dma_data got=%h exp=00", dma_data); end
      if (cpu_dout !== 8'h00) begin bad++; $display("FAIL reset_cpu_dout got=%h exp=00", cpu_dout); end
      if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
      step();
    end
    reset = 1'b0; dma_en = 1'b0;
    step();
  endtask

  task automatic test_sweep();
    int n;
    dma_en = 1'b1; dma_addr = 13'h0000;
    wait_hit(n);
    total += 2;
    if (dma_wait !== 1'b0 || n > RD_LAT + 2) begin
      bad++; $display("FAIL sweep_first_latency wait=%b cycles=%0d exp<=%0d", dma_wait, n, RD_LAT + 2);
    end
    if (dma_data !== exp_mem[0]) begin bad++; $display("FAIL sweep_data a=0000 got=%h exp=%h", dma_data, exp_mem[0]); end
    for (int a = 1; a < 8192; a++) begin
      step();
      dma_addr = a[12:0];
      repeat (4) step();
      @(negedge clk_sys);
      total += 2;
      if (dma_wait !== 1'b0) begin bad++; $display("FAIL sweep_wait a=%h got=%b exp=0", a[12:0], dma_wait); end
      if (dma_data !== exp_mem[a]) begin bad++; $display("FAIL sweep_data a=%h got=%h exp=%h", a[12:0], dma_data, exp_mem[a]); end
    end
    step();
  endtask

  task automatic test_cpu_burst();
    int n;
    logic [12:0] wa;
    dma_addr = 13'h0100;
    wait_hit(n);
    total++;
    if (n >= 20 || dma_data !== exp_mem[13'h0100]) begin
      bad++; $display("FAIL burst_start got=%h exp=%h cycles=%0d", dma_data, exp_mem[13'h0100], n);
    end
    repeat (5) step();
    // reader jumps to a non-prefetched byte while the CPU hogs the port
    dma_addr = 13'h0105;
    for (int i = 0; i < 20; i++) begin
      wa = 13'h1000 + 13'(i);
      cpu_wr = 1'b1; cpu_addr = wa; cpu_din = 8'hC0 + 8'(i);
      exp_mem[wa] = 8'hC0 + 8'(i);
      @(negedge clk_sys);
      total += 2;
      if (ram_we !== 1'b1 || ram_addr !== wa || ram_din !== 8'hC0 + 8'(i)) begin
        bad++; $display("FAIL burst_port i=%0d we=%b addr=%h din=%h exp addr=%h", i, ram_we, ram_addr, ram_din, wa);
      end
      if (dma_wait !== 1'b1) begin bad++; $display("FAIL burst_wait i=%0d got=%b exp=1", i, dma_wait); end
      step();
    end
    cpu_wr = 1'b0;
    wait_hit(n);
    total++;
    if (n >= 20 || dma_data !== exp_mem[13'h0105]) begin
      bad++; $display("FAIL burst_resume got=%h exp=%h cycles=%0d", dma_data, exp_mem[13'h0105], n);
    end
    for (int a = 13'h0106; a <= 13'h0108; a++) begin
      step();
      dma_addr = a[12:0];
      repeat (4) step();
      @(negedge clk_sys);
      total++;
      if (dma_wait !== 1'b0 || dma_data !== exp_mem[a]) begin
        bad++; $display("FAIL burst_sweep a=%h wait=%b got=%h exp=%h", a[12:0], dma_wait, dma_data, exp_mem[a]);
      end
    end
    step();
    // rd and wr together behave as a write
    cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 13'h1100; cpu_din = 8'h3C;
    exp_mem[13'h1100] = 8'h3C;
    @(negedge clk_sys);
    total++;
    if (ram_we !== 1'b1) begin bad++; $display("FAIL rdwr_is_write we=%b exp=1", ram_we); end
    step();
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wa = (k == 3) ? 13'h1100 : 13'h1000 + 13'(k * 9);
      cpu_rd = 1'b1; cpu_addr = wa;
      step();
      cpu_rd = 1'b0;
      step();
      @(negedge clk_sys);
      total++;
      if (cpu_dout !== exp_mem[wa]) begin bad++; $display("FAIL cpu_readback a=%h got=%h exp=%h", wa, cpu_dout, exp_mem[wa]); end
    end
    step();
  endtask

  task automatic test_coherency();
    int n;
    dma_en = 1'b0;
    cpu_wr = 1'b1; cpu_addr = 13'h0123; cpu_din = 8'h55;
    exp_mem[13'h0123] = 8'h55;
    step();
    cpu_wr = 1'b0; dma_en = 1'b1; dma_addr = 13'h0123;
    wait_hit(n);
    total++;
    if (n >= 20 || dma_data !== 8'h55) begin bad++; $display("FAIL coh_hold got=%h exp=55 cycles=%0d", dma_data, n); end
    repeat (4) step();
    cpu_wr = 1'b1; cpu_addr = 13'h0123; cpu_din = 8'hAA;
    exp_mem[13'h0123] = 8'hAA;
    @(negedge clk_sys);
    total++;
    if (dma_wait !== 1'b0) begin bad++; $display("FAIL coh_wait_same_cycle got=%b exp=0", dma_wait); end
    step();
    cpu_wr = 1'b0;
    @(negedge clk_sys);
    total++;
    if (dma_wait !== 1'b1) begin bad++; $display("FAIL coh_wait_rise got=%b exp=1", dma_wait); end
    step();
    wait_hit(n);
    total++;
    if (n >= 20 || dma_data !== 8'hAA) begin bad++; $display("FAIL coh_reread got=%h exp=AA cycles=%0d", dma_data, n); end
    repeat (4) step();
    // 0x0124 is now prefetched with its old value; overwrite it
    cpu_wr = 1'b1; cpu_addr = 13'h0124; cpu_din = 8'h77;
    exp_mem[13'h0124] = 8'h77;
    step();
    cpu_wr = 1'b0;
    repeat (3) step();
    dma_addr = 13'h0124;
    wait_hit(n);
    total++;
    if (n >= 20 || dma_data !== 8'h77) begin bad++; $display("FAIL coh_prefetch got=%h exp=77 cycles=%0d", dma_data, n); end
    step();
  endtask

  task automatic test_wrap();
    int n;
    dma_en = 1'b0;
    step();
    dma_en = 1'b1; dma_addr = 13'h1FFF;
    wait_hit(n);
    total += 2;
    if (n >= 20 || dma_data !== exp_mem[13'h1FFF]) begin
      bad++; $display("FAIL wrap_hold got=%h exp=%h cycles=%0d", dma_data, exp_mem[13'h1FFF], n);
    end
    if (ram_addr !== 13'h0000 || ram_we !== 1'b0) begin
      bad++; $display("FAIL wrap_pf_addr got=%h we=%b exp=0000 we=0", ram_addr, ram_we);
    end
    repeat (4) step();
    dma_addr = 13'h0000;
    @(negedge clk_sys);
    total++;
    if (dma_wait !== 1'b1) begin bad++; $display("FAIL wrap_promote_wait got=%b exp=1", dma_wait); end
    step();
    @(negedge clk_sys);
    total += 2;
    if (dma_wait !== 1'b0) begin bad++; $display("FAIL wrap_wait got=%b exp=0", dma_wait); end
    if (dma_data !== exp_mem[0]) begin bad++; $display("FAIL wrap_data got=%h exp=%h", dma_data, exp_mem[0]); end
    step();
  endtask

  task automatic test_reset_inflight();
    int n;
    dma_addr = 13'h0777;
    @(negedge clk_sys);
    total++;
    if (ram_addr !== 13'h0777 || ram_we !== 1'b0) begin
      bad++; $display("FAIL rst_issue got=%h we=%b exp=0777 we=0", ram_addr, ram_we);
    end
    step();
    reset = 1'b1; dma_addr = 13'h0040;
    @(negedge clk_sys);
    total++;
    if (dma_wait !== 1'b1) begin bad++; $display("FAIL rst_wait got=%b exp=1", dma_wait); end
    step();
    @(negedge clk_sys);
    total++;
    if (dma_data !== 8'h00) begin bad++; $display("FAIL rst_clear got=%h exp=00", dma_data); end
    step();
    reset = 1'b0;
    wait_hit(n);
    total++;
    if (n >= 20 || dma_data !== exp_mem[13'h0040]) begin
      bad++; $display("FAIL rst_first_byte got=%h exp=%h cycles=%0d", dma_data, exp_mem[13'h0040], n);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_cpu_burst();
    test_coherency();
    test_wrap();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
